// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, frame constants
// and baud-rate helpers. Optional parity bit is enabled by UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DataBits = 8;
    localparam int StopBits = 1;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer; dout is valid in the pop cycle.
module uart_tx_fifo #(
    parameter int Depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int AW = $clog2(Depth);

    logic [7:0]    mem [Depth];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_fifo_transmitter.sv
// FIFO-buffered UART transmitter producing 8N1 frames on SOut.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_fifo_transmitter
    import uart_pkg::*;
#(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200,
    parameter int FifoDepth = 4
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic [7:0]                   DataIn,
    input  logic                         DataInValid,
    output logic                         DataInReady,
    output logic                         SOut,
    output logic                         TxBusy,
    output logic [$clog2(FifoDepth):0]   FifoCount
);

    localparam int SymbolEdgeTime = symbol_edge_time(ClockFreq, BaudRate);
    localparam int BW             = cnt_width(SymbolEdgeTime);

    state_t        state;
    state_t        state_n;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_n;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;
    logic          pop;
    logic          push;
    logic          full;
    logic          empty;
    logic [7:0]    fifo_dout;
    logic          sout;
    logic          baud_last;

    assign push        = DataInValid && !full;
    assign DataInReady = !full;
    assign SOut        = sout;
    assign TxBusy      = (state != IDLE) || (FifoCount != '0);
    assign baud_last   = (baud == BW'(SymbolEdgeTime - 1));

    uart_tx_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk   (CLK),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (DataIn),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (FifoCount)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
        end
    end

    // Data bits rotate rather than shift so the byte is intact for parity.
    always_comb begin
        state_n = state;
        baud_n  = baud + BW'(1);
        bit_n   = bit_cnt;
        shift_n = shift;
        pop     = 1'b0;
        sout    = 1'b1;
        unique case (state)
            IDLE: begin
                baud_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    bit_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                sout = 1'b0;
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                sout = shift[0];
                if (baud_last) begin
                    baud_n  = '0;
                    shift_n = {shift[0], shift[7:1]};
                    if (bit_cnt == 3'(DataBits - 1)) begin
                        bit_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                sout = ^shift;
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_cnt == 3'(StopBits - 1)) begin
                        bit_n = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_n = fifo_dout;
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                baud_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// Directed bench for uart_fifo_transmitter at 10 clocks per bit, depth 4.
// Frame length follows UART_TX_PARITY_EN.
module tb_uart_fifo_transmitter;

    localparam int Set = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * Set;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] DataIn = 8'h00;
    logic       DataInValid = 1'b0;
    logic       DataInReady;
    logic       SOut;
    logic       TxBusy;
    logic [2:0] FifoCount;

    int   checks = 0;
    int   errors = 0;
    bit   cap = 1'b0;
    logic q[$];

    uart_fifo_transmitter #(
        .ClockFreq (1000),
        .BaudRate  (100),
        .FifoDepth (4)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .DataIn      (DataIn),
        .DataInValid (DataInValid),
        .DataInReady (DataInReady),
        .SOut        (SOut),
        .TxBusy      (TxBusy),
        .FifoCount   (FifoCount)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        if (cap) q.push_back(SOut);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    // Called #1 after the edge where the start bit should have just appeared.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [10:0] fr;
        logic        bad;
        logic        got;
        fr = frame_bits(b);
        for (int i = 0; i < NB; i++) begin
            bad = 1'b0;
            got = fr[i];
            for (int c = 0; c < Set; c++) begin
                if (SOut !== fr[i] && !bad) begin
                    bad = 1'b1;
                    got = SOut;
                end
                step();
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s bit %0d: SOut=%b required %b for %0d cycles",
                         tag, i, got, fr[i], Set);
            end
        end
    endtask

    task automatic test_reset();
        logic bad;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (SOut !== 1'b1) begin
            errors++; $display("FAIL reset_sout: got %b required 1", SOut);
        end
        checks++;
        if (DataInReady !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b required 1", DataInReady);
        end
        checks++;
        if (TxBusy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b required 0", TxBusy);
        end
        checks++;
        if (FifoCount !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d required 0", FifoCount);
        end
        bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (SOut !== 1'b1 || TxBusy !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL reset_quiet: line active, required idle 50 cycles");
        end
    endtask

    task automatic test_single();
        DataIn = 8'h41;
        DataInValid = 1'b1;
        step();
        DataInValid = 1'b0;
        checks++;
        if (FifoCount !== 3'd1) begin
            errors++; $display("FAIL single_count: got %0d required 1", FifoCount);
        end
        checks++;
        if (SOut !== 1'b1) begin
            errors++; $display("FAIL single_latency: SOut=%b required 1 before pop", SOut);
        end
        step();
        checks++;
        if (FifoCount !== 3'd0 || TxBusy !== 1'b1) begin
            errors++;
            $display("FAIL single_pop: count=%0d busy=%b required 0 and 1",
                     FifoCount, TxBusy);
        end
        check_frame(8'h41, "single_41");
        checks++;
        if (TxBusy !== 1'b0 || SOut !== 1'b1) begin
            errors++;
            $display("FAIL single_done: busy=%b sout=%b required 0 and 1", TxBusy, SOut);
        end
    endtask

    task automatic test_burst();
        int acc;
        q.delete();
        cap = 1'b1;
        acc = 0;
        DataInValid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            DataIn = 8'h10 + 8'(i);
            if (DataInReady) acc++;
            step();
        end
        checks++;
        if (acc != 5) begin
            errors++; $display("FAIL burst_accepted: got %0d required 5", acc);
        end
        checks++;
        if (FifoCount !== 3'd4 || DataInReady !== 1'b0) begin
            errors++;
            $display("FAIL burst_full: count=%0d ready=%b required 4 and 0",
                     FifoCount, DataInReady);
        end
    endtask

    task automatic test_full_ignore();
        logic bad;
        bad = 1'b0;
        DataIn = 8'h99;
        DataInValid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (FifoCount !== 3'd4 || DataInReady !== 1'b0) bad = 1'b1;
        end
        DataInValid = 1'b0;
        checks++;
        if (bad) begin
            errors++; $display("FAIL full_ignore: count left 4 or ready rose while full");
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        int idx;
        logic [10:0] fr;
        logic bad;
        edges = 26;
        while (edges < 1 + FL) begin
            step();
            edges++;
        end
        checks++;
        if (DataInReady !== 1'b0) begin
            errors++; $display("FAIL ready_early: got %b required 0", DataInReady);
        end
        step();
        edges++;
        checks++;
        if (DataInReady !== 1'b1 || FifoCount !== 3'd3) begin
            errors++;
            $display("FAIL ready_rise: ready=%b count=%0d required 1 and 3",
                     DataInReady, FifoCount);
        end
        while (edges < 1 + 5 * FL + 20) begin
            step();
            edges++;
        end
        cap = 1'b0;
        checks++;
        if (q.size() != 1 + 5 * FL + 20) begin
            errors++;
            $display("FAIL stream_len: got %0d required %0d", q.size(), 1 + 5 * FL + 20);
        end
        checks++;
        if (q.size() < 1 || q[0] !== 1'b1) begin
            errors++; $display("FAIL stream_lead: SOut not idle before first frame");
        end
        for (int f = 0; f < 5; f++) begin
            fr = frame_bits(8'h10 + 8'(f));
            bad = 1'b0;
            for (int i = 0; i < NB; i++) begin
                for (int c = 0; c < Set; c++) begin
                    idx = 1 + f * FL + i * Set + c;
                    if (idx >= q.size() || q[idx] !== fr[i]) bad = 1'b1;
                end
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL stream_frame%0d: byte %h not seen back to back",
                         f, 8'h10 + 8'(f));
            end
        end
        bad = 1'b0;
        for (int k = 1 + 5 * FL; k < 1 + 5 * FL + 20; k++) begin
            if (k >= q.size() || q[k] !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL stream_tail: extra frame after 0x14 (0x99 sent?)");
        end
        checks++;
        if (TxBusy !== 1'b0 || FifoCount !== 3'd0) begin
            errors++;
            $display("FAIL burst_idle: busy=%b count=%0d required 0 and 0",
                     TxBusy, FifoCount);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] fr;
        logic bad;
        fr = frame_bits(8'h55);
        DataInValid = 1'b1;
        DataIn = 8'h55;
        step();
        DataIn = 8'hAA;
        step();
        DataIn = 8'h33;
        step();
        DataInValid = 1'b0;
        checks++;
        if (FifoCount !== 3'd2) begin
            errors++; $display("FAIL mid_queued: got %0d required 2", FifoCount);
        end
        for (int c = 0; c < 33; c++) step();
        checks++;
        if (SOut !== fr[3]) begin
            errors++; $display("FAIL mid_bit: SOut=%b required %b", SOut, fr[3]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (SOut !== 1'b1 || FifoCount !== 3'd0 || TxBusy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: sout=%b count=%0d busy=%b required 1 0 0",
                     SOut, FifoCount, TxBusy);
        end
        bad = 1'b0;
        for (int c = 0; c < 250; c++) begin
            step();
            if (SOut !== 1'b1 || TxBusy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL mid_quiet: frame sent after reset");
        end
    endtask

    task automatic test_parity();
        DataIn = 8'h07;
        DataInValid = 1'b1;
        step();
        DataInValid = 1'b0;
        step();
        check_frame(8'h07, "parity_07");
        checks++;
        if (SOut !== 1'b1 || TxBusy !== 1'b0) begin
            errors++;
            $display("FAIL parity_07_end: sout=%b busy=%b required 1 and 0", SOut, TxBusy);
        end
        DataIn = 8'h41;
        DataInValid = 1'b1;
        step();
        DataInValid = 1'b0;
        step();
        check_frame(8'h41, "parity_41");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_ignore();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_fifo_transmitter.md
Name: uart_fifo_transmitter

Overview:
- Serial transmit end of the CPU's UART write path.
- Accepts bytes from the datapath's store-to-UART port through a ready/valid handshake (DataIn, DataInValid, DataInReady).
- Buffers accepted bytes in a small FIFO and serializes each one onto SOut as an 8N1 frame at a fixed baud rate.
- Sits between the datapath's UART write port and the board TX pin.

Parameters:
- ClockFreq, 50_000_000, CLK frequency in Hz.
- BaudRate, 115_200, line rate in bits/s. Cycles per bit: SymbolEdgeTime = ClockFreq/BaudRate, truncated; must be ≥ 2.
- FifoDepth, 4, number of FIFO entries; power of 2, ≥ 2.

Ports:
- CLK  in  1  system clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- DataIn  in  8  byte to transmit.
- DataInValid  in  1  byte valid; may be a one-cycle pulse.
- DataInReady  out  1  FIFO can accept a byte; equals !full, combinational from registered state.
- SOut  out  1  serial line; idles high.
- TxBusy  out  1  high while a frame is on the line or the FIFO is non-empty.
- FifoCount  out  log2(FifoDepth)+1  current number of FIFO entries.

Behaviour:
- Reset is synchronous, active-high, and applies on the first rising CLK edge with reset=1. After it:
  - SOut=1, DataInReady=1, TxBusy=0, FifoCount=0.
  - FSM in IDLE; baud and bit counters cleared; FIFO pointers cleared.
  - Reset mid-frame aborts the frame: SOut=1 after that edge and buffered bytes are discarded.
- Push: a byte is written at an edge where DataInValid && DataInReady. When full, DataInReady=0 and DataInValid is ignored, even if a pop happens in the same cycle.
- Pop: done only by the FSM. Simultaneous push and pop leaves FifoCount unchanged. Pointers wrap modulo FifoDepth.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: SOut=1. If FIFO non-empty at an edge: pop into the shift register, clear the counters, go to START.
  - START: SOut=0 for SymbolEdgeTime cycles, then go to DATA.
  - DATA: SOut = shift[0], LSB first. Each bit is held SymbolEdgeTime cycles. After 8 bits, go to STOP.
  - STOP: SOut=1 for SymbolEdgeTime cycles. At its final cycle, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: byte accepted at edge k into an empty FIFO in IDLE; popped at edge k+1; SOut falls after edge k+1.
- Frame length: exactly 10*SymbolEdgeTime cycles.
- Baud counter counts 0..SymbolEdgeTime-1 and wraps. Bit counter counts 0..7.
- TxBusy = (state != IDLE) || (FifoCount != 0).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, held SymbolEdgeTime cycles. SOut = ^data (even parity). The frame becomes 11 bit-times.
- Undefined: no PARITY state; 8N1 frame of 10 bit-times.

Decomposition:
- Shared package/header uart_pkg:
  - FSM state encodings (IDLE, START, DATA, PARITY, STOP).
  - Frame constants: DataBits=8, StopBits=1.
  - SymbolEdgeTime computation function and counter-width function.
- Sub-module uart_tx_fifo: synchronous FIFO with push, pop, dout, full, empty, count.
  - dout is combinational from the read pointer, so data is available in the pop cycle.
  - The top level contains the FSM, baud/bit counters and shift register.

Test Plan (ClockFreq=1000, BaudRate=100, so 10 cycles/bit; FifoDepth=4):
- Reset: assert reset for 2 cycles → SOut=1, DataInReady=1, TxBusy=0, FifoCount=0. No SOut activity for 50 cycles.
- Single byte 0x41 pulsed at edge k:
  - SOut falls after edge k+1.
  - Bit values 0,1,0,0,0,0,0,1,0,1, each exactly 10 cycles.
  - TxBusy drops after 100 cycles.
- Burst: DataInValid held with bytes 0x10..0x15 on consecutive cycles:
  - Exactly 5 bytes are accepted (0x10 is popped at the second edge), then DataInReady=0 and FifoCount=4.
  - DataInReady rises in the cycle after the first frame ends.
  - Frames appear back to back with no idle gap, in order.
- Full with DataInValid high: 0x99 presented while DataInReady=0 → never transmitted; FifoCount stays 4.
- Reset at cycle 35 of a 0x55 frame with 2 bytes queued:
  - SOut=1 after that edge; FifoCount=0.
  - No further frames are sent.
- UART_TX_PARITY_EN, byte 0x07:
  - 11-bit frame; the parity bit-time shows SOut=1 (three ones, so even parity bit is 1).
  - Byte 0x41 gives parity 0.
